// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Central sequencer for the five-stage pipeline latches. From the cache
//   handshakes, load-use detection, taken branches and halt it produces the
//   PC enable and the per-latch enable/flush controls. It also runs a
//   RUN/MEMWAIT/HALT state machine, keeps saturating stall and flush counters,
//   and raises a sticky watchdog flag when a data access waits too long.
//
// Parameters
//   CNT_W        width of stall_cnt / flush_cnt
//   MEM_TIMEOUT  MEMWAIT cycles after which mem_timeout is raised (>= 1)
//
// Ports
//   CLK, nRST                      clock (posedge), asynchronous active-low reset
//   ihit, dhit                     fetch / data access completes this cycle
//   mem_dREN, mem_dWEN             EX/MEM latch holds a load / store
//   ex_dREN, ex_wsel               ID/EX latch holds a load and its destination
//   id_rs, id_rt, id_uses_rt       source registers of the decode instruction
//   ex_branch_taken                PC redirect resolved in EX
//   wb_halt                        halt has reached the MEM/WB output
//   pc_en                          PC load enable
//   ifid_en/_flush, idex_en/_flush IF/ID and ID/EX latch controls
//   exmem_en/_flush, memwb_en      EX/MEM and MEM/WB latch controls
//   halted                         pipeline halted, held until reset
//   mem_timeout                    sticky watchdog flag
//   stall_cnt, flush_cnt           saturating performance counters

module pipeline_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             ex_dREN,
    input  logic [4:0]       ex_wsel,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_branch_taken,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // One extra count of headroom so the watchdog can sit at MEM_TIMEOUT.
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALT    = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              mem_req;
    logic              dstall;
    logic              load_use;
    logic              halt_now;
    logic [WAIT_W-1:0] wait_cnt;

    assign mem_req  = mem_dREN | mem_dWEN;
    assign dstall   = mem_req & ~dhit;
    // Register 0 is hardwired, so a load into it never creates a hazard.
    assign load_use = ex_dREN & (ex_wsel != 5'd0) &
                      ((ex_wsel == id_rs) | (id_uses_rt & (ex_wsel == id_rt)));
    // wb_halt takes effect in the same cycle it appears, before HALT is entered.
    assign halt_now = (state == HALT) | wb_halt;

    // No condition currently needs to squash EX/MEM.
    assign exmem_flush = 1'b0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            RUN: begin
                if (wb_halt) begin
                    next_state = HALT;
                end else if (dstall) begin
                    next_state = MEMWAIT;
                end
            end
            MEMWAIT: begin
                if (wb_halt) begin
                    next_state = HALT;
                end else if (dhit) begin
                    next_state = RUN;
                end
            end
            HALT: begin
                next_state = HALT;
            end
            default: begin
                next_state = RUN;
            end
        endcase
    end

    // Priority chain: halt, data stall, redirect, load-use bubble, fetch miss.
    // Flushes are raised alongside a deasserted enable so a flushed latch
    // always loads its reset values.
    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_en    = 1'b0;
        idex_flush = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        halted     = 1'b0;
        if (nRST) begin
            if (halt_now) begin
                halted = 1'b1;
            end else if (dstall) begin
                pc_en = 1'b0;
            end else if (ex_branch_taken) begin
                pc_en      = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end else if (load_use) begin
                idex_flush = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end else if (!ihit) begin
                ifid_flush = 1'b1;
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end else begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
            end
        end
    end

    // wait_cnt holds the number of MEMWAIT cycles completed so far; it stops
    // at MEM_TIMEOUT so a very long wait cannot wrap it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            if ((state == RUN) && (next_state == MEMWAIT)) begin
                wait_cnt <= '0;
            end else if ((state == MEMWAIT) && (wait_cnt != WAIT_W'(MEM_TIMEOUT))) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if ((state == MEMWAIT) && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1))) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    // The cycle that raises halted already counts as halted, so counters freeze then.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!halted) begin
            if (!pc_en && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (idex_flush && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
//   Self-checking bench for pipeline_ctrl: a table of single-cycle vectors,
//   hand-written multi-cycle sequences (data stall, watchdog, reset mid-wait,
//   halt, counter saturation) and a randomized run compared against a
//   behavioural model of the controller.

module tb_pipeline_ctrl;

    localparam int TB_CNT_W   = 4;
    localparam int TB_TIMEOUT = 4;
    localparam int CNT_MAX    = (1 << TB_CNT_W) - 1;

    // Control bundle order: pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
    // exmem_en, exmem_flush, memwb_en, halted.
    localparam logic [8:0] NORMAL_V = 9'b110101010;
    localparam logic [8:0] BRANCH_V = 9'b101011010;
    localparam logic [8:0] BUBBLE_V = 9'b000011010;
    localparam logic [8:0] FETCH_V  = 9'b001101010;
    localparam logic [8:0] FROZEN_V = 9'b000000000;
    localparam logic [8:0] HALT_V   = 9'b000000001;

    typedef struct packed {
        logic       ihit;
        logic       dhit;
        logic       mem_dREN;
        logic       mem_dWEN;
        logic       ex_dREN;
        logic [4:0] ex_wsel;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_uses_rt;
        logic       br;
        logic       wb_halt;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic [8:0] exp;
    } vec_t;

    logic                CLK = 1'b0;
    logic                nRST;
    logic                ihit, dhit, mem_dREN, mem_dWEN, ex_dREN;
    logic [4:0]          ex_wsel, id_rs, id_rt;
    logic                id_uses_rt, ex_branch_taken, wb_halt;
    logic                pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic                exmem_en, exmem_flush, memwb_en, halted, mem_timeout;
    logic [TB_CNT_W-1:0] stall_cnt, flush_cnt;
    logic [8:0]          outs;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit    mHalt;
    bit    mWait;
    bit    mTO;
    int    mWaitCycles;
    int    mStall;
    int    mFlush;
    stim_t curStim;
    vec_t  vecs[$];

    pipeline_ctrl #(
        .CNT_W      (TB_CNT_W),
        .MEM_TIMEOUT(TB_TIMEOUT)
    ) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .ihit           (ihit),
        .dhit           (dhit),
        .mem_dREN       (mem_dREN),
        .mem_dWEN       (mem_dWEN),
        .ex_dREN        (ex_dREN),
        .ex_wsel        (ex_wsel),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .ex_branch_taken(ex_branch_taken),
        .wb_halt        (wb_halt),
        .pc_en          (pc_en),
        .ifid_en        (ifid_en),
        .ifid_flush     (ifid_flush),
        .idex_en        (idex_en),
        .idex_flush     (idex_flush),
        .exmem_en       (exmem_en),
        .exmem_flush    (exmem_flush),
        .memwb_en       (memwb_en),
        .halted         (halted),
        .mem_timeout    (mem_timeout),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    assign outs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                   exmem_en, exmem_flush, memwb_en, halted};

    always #5 CLK = ~CLK;

    function automatic stim_t idleStim();
        stim_t s;
        s      = '0;
        s.ihit = 1'b1;
        return s;
    endfunction

    function automatic stim_t randStim();
        stim_t s;
        s.ihit       = ($urandom_range(0, 3) != 0);
        s.dhit       = 1'($urandom_range(0, 1));
        s.mem_dREN   = ($urandom_range(0, 3) == 0);
        s.mem_dWEN   = ($urandom_range(0, 5) == 0);
        s.ex_dREN    = 1'($urandom_range(0, 1));
        s.ex_wsel    = 5'($urandom_range(0, 3));
        s.id_rs      = 5'($urandom_range(0, 3));
        s.id_rt      = 5'($urandom_range(0, 3));
        s.id_uses_rt = 1'($urandom_range(0, 1));
        s.br         = ($urandom_range(0, 4) == 0);
        s.wb_halt    = ($urandom_range(0, 79) == 0);
        return s;
    endfunction

    // Expected control bundle straight from the priority rules.
    function automatic logic [8:0] expectOut(input stim_t s, input bit halting);
        bit dataWait;
        bit hazard;
        dataWait = (s.mem_dREN || s.mem_dWEN) && !s.dhit;
        hazard   = s.ex_dREN && (s.ex_wsel != 0) &&
                   ((s.ex_wsel == s.id_rs) || (s.id_uses_rt && (s.ex_wsel == s.id_rt)));
        if (halting)  return HALT_V;
        if (dataWait) return FROZEN_V;
        if (s.br)     return BRANCH_V;
        if (hazard)   return BUBBLE_V;
        if (!s.ihit)  return FETCH_V;
        return NORMAL_V;
    endfunction

    task automatic modelReset();
        mHalt       = 1'b0;
        mWait       = 1'b0;
        mTO         = 1'b0;
        mWaitCycles = 0;
        mStall      = 0;
        mFlush      = 0;
    endtask

    // Advance the model across one clock edge with stimulus s.
    task automatic modelUpdate(input stim_t s);
        bit         halting;
        bit         dataWait;
        logic [8:0] e;
        halting  = mHalt || s.wb_halt;
        e        = expectOut(s, halting);
        dataWait = (s.mem_dREN || s.mem_dWEN) && !s.dhit;
        if (!halting) begin
            if (!e[8]) mStall = (mStall < CNT_MAX) ? mStall + 1 : CNT_MAX;
            if (e[4])  mFlush = (mFlush < CNT_MAX) ? mFlush + 1 : CNT_MAX;
        end
        if (!mHalt && mWait) begin
            mWaitCycles++;
            if (mWaitCycles >= TB_TIMEOUT) mTO = 1'b1;
        end
        if (!mHalt) begin
            if (s.wb_halt) begin
                mHalt = 1'b1;
                mWait = 1'b0;
            end else if (mWait) begin
                if (s.dhit) mWait = 1'b0;
            end else if (dataWait) begin
                mWait       = 1'b1;
                mWaitCycles = 0;
            end
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        curStim         = s;
        ihit            = s.ihit;
        dhit            = s.dhit;
        mem_dREN        = s.mem_dREN;
        mem_dWEN        = s.mem_dWEN;
        ex_dREN         = s.ex_dREN;
        ex_wsel         = s.ex_wsel;
        id_rs           = s.id_rs;
        id_rt           = s.id_rt;
        id_uses_rt      = s.id_uses_rt;
        ex_branch_taken = s.br;
        wb_halt         = s.wb_halt;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkModel();
        checkOutput("model_ctrl", 32'(outs), 32'(expectOut(curStim, mHalt || curStim.wb_halt)));
        checkOutput("model_stall_cnt", 32'(stall_cnt), 32'(mStall));
        checkOutput("model_flush_cnt", 32'(flush_cnt), 32'(mFlush));
        checkOutput("model_mem_timeout", 32'(mem_timeout), 32'(mTO));
    endtask

    // Called two time units after a rising edge.
    task automatic startCycle(input stim_t s);
        applyStimulus(s);
        #2;
        checkModel();
    endtask

    task automatic endCycle();
        @(posedge CLK);
        modelUpdate(curStim);
        #2;
    endtask

    task automatic doReset();
        nRST = 1'b0;
        #2;
        checkOutput("rst_ctrl", 32'(outs), 32'(FROZEN_V));
        checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        checkOutput("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        checkOutput("rst_mem_timeout", 32'(mem_timeout), 32'd0);
        applyStimulus(idleStim());
        @(negedge CLK);
        nRST = 1'b1;
        modelReset();
        @(posedge CLK);
        modelUpdate(curStim);
        #2;
    endtask

    task automatic addVec(input stim_t s, input logic [8:0] e);
        vec_t v;
        v.s   = s;
        v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        stim_t s;

        nRST = 1'b1;
        applyStimulus(idleStim());
        modelReset();
        #1;
        doReset();

        // Single-cycle vectors
        s = idleStim();                                                      addVec(s, NORMAL_V);
        s = idleStim(); s.ex_dREN = 1; s.ex_wsel = 8; s.id_rs = 8;           addVec(s, BUBBLE_V);
        s = idleStim(); s.ex_dREN = 1; s.ex_wsel = 0; s.id_rs = 0;           addVec(s, NORMAL_V);
        s = idleStim(); s.ex_dREN = 1; s.ex_wsel = 5; s.id_rt = 5; s.id_uses_rt = 1; addVec(s, BUBBLE_V);
        s = idleStim(); s.ex_dREN = 1; s.ex_wsel = 5; s.id_rt = 5;           addVec(s, NORMAL_V);
        s = idleStim(); s.ex_wsel = 8; s.id_rs = 8;                          addVec(s, NORMAL_V);
        s = idleStim(); s.ex_dREN = 1; s.ex_wsel = 8; s.id_rs = 8; s.br = 1; addVec(s, BRANCH_V);
        s = idleStim(); s.ihit = 0;                                          addVec(s, FETCH_V);
        s = idleStim(); s.ihit = 0; s.ex_dREN = 1; s.ex_wsel = 3; s.id_rs = 3; addVec(s, BUBBLE_V);
        s = idleStim(); s.ihit = 0; s.br = 1;                                addVec(s, BRANCH_V);
        s = idleStim(); s.mem_dWEN = 1; s.dhit = 1;                          addVec(s, NORMAL_V);
        s = idleStim(); s.mem_dREN = 1; s.br = 1;                            addVec(s, FROZEN_V);
        s = idleStim(); s.mem_dREN = 1; s.dhit = 1;                          addVec(s, NORMAL_V);

        for (int i = 0; i < vecs.size(); i++) begin
            startCycle(vecs[i].s);
            checkOutput($sformatf("vec%0d", i), 32'(outs), 32'(vecs[i].exp));
            endCycle();
        end

        // Data-cache stall: three frozen cycles, then advance on the hit.
        doReset();
        s = idleStim(); s.mem_dREN = 1;
        for (int c = 0; c < 3; c++) begin
            startCycle(s);
            checkOutput("dstall_frozen", 32'(outs), 32'(FROZEN_V));
            endCycle();
        end
        s.dhit = 1;
        startCycle(s);
        checkOutput("dstall_release", 32'(outs), 32'(NORMAL_V));
        endCycle();
        checkOutput("dstall_stall_cnt", 32'(stall_cnt), 32'd3);

        // Watchdog: rises after the fourth MEMWAIT cycle and stays set.
        doReset();
        s = idleStim(); s.mem_dREN = 1;
        for (int c = 1; c <= 6; c++) begin
            startCycle(s);
            checkOutput($sformatf("timeout_c%0d", c), 32'(mem_timeout), (c == 6) ? 32'd1 : 32'd0);
            endCycle();
        end
        s.dhit = 1;
        startCycle(s);
        checkOutput("timeout_hit_ctrl", 32'(outs), 32'(NORMAL_V));
        endCycle();
        startCycle(idleStim());
        checkOutput("timeout_sticky", 32'(mem_timeout), 32'd1);
        endCycle();

        // Reset pulse while waiting on the data cache.
        doReset();
        s = idleStim(); s.mem_dREN = 1;
        startCycle(s); endCycle();
        startCycle(s); endCycle();
        startCycle(idleStim());
        checkOutput("midrst_pre_ctrl", 32'(outs), 32'(NORMAL_V));
        doReset();
        checkOutput("midrst_stall_cnt", 32'(stall_cnt), 32'd0);
        for (int c = 0; c < 5; c++) begin
            startCycle(idleStim());
            endCycle();
        end
        checkOutput("midrst_run_no_timeout", 32'(mem_timeout), 32'd0);

        // Halt during a data stall: immediate, terminal, counters frozen.
        doReset();
        s = idleStim(); s.ihit = 0;
        startCycle(s); endCycle();
        startCycle(s); endCycle();
        checkOutput("halt_pre_stall_cnt", 32'(stall_cnt), 32'd2);
        s = idleStim(); s.mem_dREN = 1; s.wb_halt = 1; s.br = 1;
        startCycle(s);
        checkOutput("halt_same_cycle", 32'(outs), 32'(HALT_V));
        endCycle();
        for (int c = 0; c < 3; c++) begin
            s = idleStim(); s.ihit = 0; s.br = (c == 1);
            startCycle(s);
            checkOutput("halt_held", 32'(outs), 32'(HALT_V));
            endCycle();
        end
        checkOutput("halt_stall_frozen", 32'(stall_cnt), 32'd2);
        checkOutput("halt_flush_frozen", 32'(flush_cnt), 32'd0);

        // Counter saturation.
        doReset();
        s = idleStim(); s.ihit = 0;
        for (int c = 0; c < CNT_MAX + 5; c++) begin
            startCycle(s); endCycle();
        end
        checkOutput("sat_stall_cnt", 32'(stall_cnt), 32'(CNT_MAX));
        s = idleStim(); s.br = 1;
        for (int c = 0; c < CNT_MAX + 5; c++) begin
            startCycle(s); endCycle();
        end
        checkOutput("sat_flush_cnt", 32'(flush_cnt), 32'(CNT_MAX));
        checkOutput("sat_stall_hold", 32'(stall_cnt), 32'(CNT_MAX));

        // Randomized run against the model, with periodic resets.
        doReset();
        for (int i = 0; i < 600; i++) begin
            if ((i % 150) == 149) doReset();
            startCycle(randStim());
            endCycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
